led_seq_ctrl: RTL

//  Pattern sequencer/controller for the green LED bank. Consumes a 1-cycle step strobe

---
 rtl/led_seq_ctrl_if.sv | 14 +
 rtl/led_seq_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/led_seq_ctrl_if.sv
// Signal bundle between the tick/key source and the green LED sequencer.
interface led_seq_ctrl_if #(
  parameter int LED_W = 8
);
  logic             tick;
  logic [3:0]       key_n;
  logic [LED_W-1:0] led_g;
  logic [1:0]       mode;
  logic             paused;
  logic             dir;

  modport master (output tick, key_n, input led_g, mode, paused, dir);
  modport slave  (input tick, key_n, output led_g, mode, paused, dir);
endinterface

// File: rtl/led_seq_ctrl.sv
// Green LED bank pattern sequencer: key-driven mode FSM (shift/bounce/blink/count)
// stepped by a clock-enable tick with pause, speed and direction control.
module led_seq_ctrl #(
  parameter int LED_W = 8,
  parameter int SPD_W = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  led_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    M_SHIFT  = 2'd0,
    M_BOUNCE = 2'd1,
    M_BLINK  = 2'd2,
    M_COUNT  = 2'd3
  } mode_e;

  localparam logic [LED_W-1:0] LED_ONE = {{(LED_W-1){1'b0}}, 1'b1};
  localparam logic [LED_W-1:0] LED_TOP = {1'b1, {(LED_W-1){1'b0}}};

  logic [3:0]       r_key_s1, r_key_s2, r_key_d, r_press;
  mode_e            r_mode, w_mode_nxt;
  logic [LED_W-1:0] r_led, w_led_nxt;
  logic             r_dir, w_dir_nxt;
  logic             r_paused, w_paused_nxt;
  logic [SPD_W-1:0] r_speed, w_speed_nxt;
  logic [SPD_W-1:0] r_tick_cnt, w_cnt_nxt;
  logic             w_qual, w_step, w_deff, w_end_flip;

  function automatic logic [LED_W-1:0] init_pat(input mode_e m, input logic d);
    if ((m == M_SHIFT) || (m == M_BOUNCE)) return d ? LED_TOP : LED_ONE;
    return '0;
  endfunction

  // Keys: 2-flop synchronizer, falling-edge detect, then a registered press pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_s1 <= '1;
      r_key_s2 <= '1;
      r_key_d  <= '1;
      r_press  <= '0;
    end else begin
      r_key_s1 <= bus.key_n;
      r_key_s2 <= r_key_s1;
      r_key_d  <= r_key_s2;
      r_press  <= r_key_d & ~r_key_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode     <= M_SHIFT;
      r_led      <= LED_ONE;
      r_dir      <= 1'b0;
      r_paused   <= 1'b0;
      r_speed    <= '1;
      r_tick_cnt <= '0;
    end else begin
      r_mode     <= w_mode_nxt;
      r_led      <= w_led_nxt;
      r_dir      <= w_dir_nxt;
      r_paused   <= w_paused_nxt;
      r_speed    <= w_speed_nxt;
      r_tick_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_qual       = bus.tick & ~r_paused;
    w_step       = w_qual & (r_tick_cnt == r_speed);
    w_deff       = r_dir ^ r_press[3];
    w_end_flip   = (r_led[LED_W-1] & ~r_dir) | (r_led[0] & r_dir);
    w_mode_nxt   = r_mode;
    w_led_nxt    = r_led;
    w_dir_nxt    = w_deff;
    w_paused_nxt = r_paused ^ r_press[1];
    w_speed_nxt  = r_press[2] ? (r_speed - 1'b1) : r_speed;
    w_cnt_nxt    = r_tick_cnt;
    if (w_qual) w_cnt_nxt = w_step ? '0 : (r_tick_cnt + 1'b1);
    if (r_press[0] | r_press[2]) w_cnt_nxt = '0;

    if (r_press[0]) begin
      w_mode_nxt = mode_e'(r_mode + 2'd1);
      w_led_nxt  = init_pat(w_mode_nxt, w_deff);
    end else if (w_step) begin
      case (r_mode)
        M_SHIFT: w_led_nxt = w_deff ? {r_led[0], r_led[LED_W-1:1]}
                                    : {r_led[LED_W-2:0], r_led[LED_W-1]};
        M_BOUNCE: begin
          // End reflection is judged on the pre-step dir; a same-cycle reverse key then toggles it back
          if (w_end_flip) begin
            w_led_nxt = r_dir ? (LED_ONE << 1) : (LED_TOP >> 1);
            w_dir_nxt = ~r_dir ^ r_press[3];
          end else if (r_led[LED_W-1] & ~w_deff) begin
            w_led_nxt = LED_TOP >> 1;
            w_dir_nxt = 1'b1;
          end else if (r_led[0] & w_deff) begin
            w_led_nxt = LED_ONE << 1;
            w_dir_nxt = 1'b0;
          end else begin
            w_led_nxt = w_deff ? (r_led >> 1) : (r_led << 1);
          end
        end
        M_BLINK: w_led_nxt = ~r_led;
        default: w_led_nxt = w_deff ? (r_led - 1'b1) : (r_led + 1'b1);
      endcase
    end else if ((r_led == '0) && ((r_mode == M_SHIFT) || (r_mode == M_BOUNCE))) begin
      w_led_nxt = init_pat(r_mode, w_deff);
    end
  end

  assign bus.led_g  = r_led;
  assign bus.mode   = r_mode;
  assign bus.paused = r_paused;
  assign bus.dir    = r_dir;

endmodule
